cardinal_router: RTL and testbench
==================================

CARDINAL_ROUTER -- requirements
Module: cardinal_router

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, flit width; bit 0 is MSB ([0:DATA_WIDTH-1]).
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports cwsi, ccwsi, pesi, input, 1 each: sender valid on CW link, CCW link and PE (NIC) injection port.
REQ-005 SHALL have ports cwri, ccwri, peri, output, 1 each: router ready on those inputs.
REQ-006 SHALL have ports cwdi, ccwdi, pedi, input, DATA_WIDTH each: input flits.
REQ-007 SHALL have ports cwso, ccwso, peso, output, 1 each: router valid on CW out, CCW out and PE delivery port.
REQ-008 SHALL have ports cwro, ccwro, pero, input, 1 each: downstream ready.
REQ-009 SHALL have ports cwdo, ccwdo, pedo, output, DATA_WIDTH each: output flits.
REQ-010 SHALL have port polarity, output, 1: current phase; exported to the attached NIC.

Function
REQ-011 SHALL interpret flit fields: bit 0 VC, bit 1 dir (0=CW, 1=CCW), bits 2:7 reserved, bits 8:15 hop, bits 16:63 opaque payload.
REQ-012 SHALL hold one 1-entry buffer per input port per VC and one per output port per VC: 12 buffers, each valid bit plus flit.
REQ-013 SHALL toggle polarity every cycle after reset; p denotes its current value.
REQ-014 SHALL perform link phase on VC p each cycle:
  - input accepted when Xsi & Xri; stored into the input buffer indexed by flit bit 0.
  - Xri = ~valid(in_X[p]).
  - Xso = valid(out_X[p]) & Xro; Xdo = data(out_X[p]).
  - out_X[p] cleared on Xso.
REQ-015 SHALL perform internal phase on VC ~p each cycle: each valid in buffer requests one output; it moves only when the target out buffer of VC ~p is empty.
REQ-016 SHALL route CW/CCW link inputs as follows:
  - hop==0: to PE output, flit unchanged.
  - else: to the same-direction output with hop field logically shifted right by 1, zero fill.
REQ-017 SHALL route PE input to CW output (dir=0) or CCW output (dir=1), flit unchanged.
REQ-018 SHALL arbitrate each contended output with a 1-bit round-robin pointer, reset value 0, which favours the first-listed requester:
  - PE out: cw_in vs ccw_in.
  - CW out: cw_in vs pe_in.
  - CCW out: ccw_in vs pe_in.
  - After a grant with both requesting, priority passes to the loser; a single requester is granted without pointer change.
REQ-019 SHALL leave a losing or blocked input buffer valid and unchanged; no flit is ever dropped or duplicated.
REQ-020 SHALL give a latency of exactly 2 cycles from link acceptance to the output presenting the flit, when unblocked: accept at p, move at ~p, send at next p.
REQ-021 SHALL never access the same buffer from both phases in one cycle: link phase and internal phase use disjoint VCs, so simultaneous fill and drain never conflict.
REQ-022 SHALL ignore Xsi while Xri=0; Xdi is don't-care when Xsi=0.
REQ-023 SHALL store the flit by its bit 0 even if that differs from p; correct senders never do this, and the bench flags it as a protocol error.

Reset
REQ-024 SHALL on reset=0, immediately and regardless of clk, set: polarity=0, all buffers invalid, flit registers 0, RR pointers 0.
REQ-025 SHALL drive outputs while in reset as: cwso=ccwso=peso=0, cwdo=ccwdo=pedo=0, cwri=ccwri=peri=1.
REQ-026 SHALL discard in-flight flits on reset mid-operation; the first edge after deassertion yields polarity=1.

Verification
REQ-027 SHALL cover single hop: cwdi=0x0000_0000_0000_00AA (VC0, hop0) accepted at p=0 -> peso=1, pedo equal, 2 cycles later; cwri stays 1.
REQ-028 SHALL cover forward: ccwdi with VC1, dir1, hop=0x03 accepted at p=1 -> ccwso=1 two cycles later with hop=0x01, other bits unchanged.
REQ-029 SHALL cover contention: cw_in and pe_in both targeting CW out in the same internal phase, repeated 4 times -> grants alternate cw, pe, cw, pe.
REQ-030 SHALL cover backpressure: hold cwro=0 for 10 cycles with traffic -> cwri drops to 0 once the VC chain fills, no loss, and all flits exit in order when cwro=1.
REQ-031 SHALL cover reset mid-flight: assert reset with 3 buffered flits -> all so=0, all ri=1, polarity=0 within the same cycle, and no stale flit emerges afterwards.
REQ-032 SHALL cover polarity: after reset, polarity sequence is 1,0,1,0 on successive edges, and only VC-p transfers occur on each link.

Source files
------------

// File: rtl/cardinal_router_if.sv
// Link bundle for the bidirectional-ring router: CW, CCW and PE ports plus the phase bit.
// Flits use [0:DATA_WIDTH-1] ordering, so bit 0 is the MSB.
interface cardinal_router_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  cwsi, ccwsi, pesi;
    logic                  cwri, ccwri, peri;
    logic [0:DATA_WIDTH-1] cwdi, ccwdi, pedi;
    logic                  cwso, ccwso, peso;
    logic                  cwro, ccwro, pero;
    logic [0:DATA_WIDTH-1] cwdo, ccwdo, pedo;
    logic                  polarity;

    modport slave (
        input  cwsi, ccwsi, pesi, cwdi, ccwdi, pedi, cwro, ccwro, pero,
        output cwri, ccwri, peri, cwso, ccwso, peso, cwdo, ccwdo, pedo, polarity
    );

    modport master (
        output cwsi, ccwsi, pesi, cwdi, ccwdi, pedi, cwro, ccwro, pero,
        input  cwri, ccwri, peri, cwso, ccwso, peso, cwdo, ccwdo, pedo, polarity
    );
endinterface

// File: rtl/cardinal_router.sv
// Two-VC ring router with one-entry buffers; even/odd phases keep link traffic on VC p
// and internal moves on VC ~p, so a buffer is never filled and drained in the same cycle.
module cardinal_router #(
    parameter int DATA_WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    cardinal_router_if.slave lnk
);
    localparam int CW  = 0;
    localparam int CCW = 1;
    localparam int PE  = 2;

    typedef logic [0:DATA_WIDTH-1] flit_t;

    logic       polarity_q, polarity_d;
    logic [1:0] in_v_q  [3];
    logic [1:0] in_v_d  [3];
    flit_t      in_f_q  [3][2];
    flit_t      in_f_d  [3][2];
    logic [1:0] out_v_q [3];
    logic [1:0] out_v_d [3];
    flit_t      out_f_q [3][2];
    flit_t      out_f_d [3][2];
    logic       rr_pe_q, rr_pe_d;
    logic       rr_cw_q, rr_cw_d;
    logic       rr_ccw_q, rr_ccw_d;

    logic       si   [3];
    logic       ro   [3];
    flit_t      di   [3];
    logic       ri   [3];
    logic       so   [3];
    flit_t      dout [3];
    logic       p, v;

    logic       cw_hop0, ccw_hop0;
    logic       req_cw_pe, req_cw_cw, req_ccw_pe, req_ccw_ccw, req_pe_cw, req_pe_ccw;
    logic [1:0] g_pe, g_cw, g_ccw;

    // Forwarded ring flits lose one hop; hop occupies bits 8:15 with bit 8 as its MSB.
    function automatic flit_t hop_shift(input flit_t f);
        flit_t r;
        r = f;
        r[8:15] = {1'b0, f[8:14]};
        return r;
    endfunction

    // Returns {grant_first, grant_second}; pointer 0 favours the first requester.
    function automatic logic [1:0] rr_grant(input logic a, input logic b, input logic ptr);
        logic [1:0] g;
        if (a && b) g = ptr ? 2'b01 : 2'b10;
        else        g = {a, b};
        return g;
    endfunction

    assign p = polarity_q;
    assign v = ~polarity_q;

    always_comb begin
        si[CW]  = lnk.cwsi;  si[CCW] = lnk.ccwsi; si[PE] = lnk.pesi;
        ro[CW]  = lnk.cwro;  ro[CCW] = lnk.ccwro; ro[PE] = lnk.pero;
        di[CW]  = lnk.cwdi;  di[CCW] = lnk.ccwdi; di[PE] = lnk.pedi;
    end

    always_comb begin
        for (int x = 0; x < 3; x++) begin
            ri[x]   = ~in_v_q[x][p];
            so[x]   = out_v_q[x][p] & ro[x];
            dout[x] = out_f_q[x][p];
        end
    end

    assign lnk.cwri     = ri[CW];
    assign lnk.ccwri    = ri[CCW];
    assign lnk.peri     = ri[PE];
    assign lnk.cwso     = so[CW];
    assign lnk.ccwso    = so[CCW];
    assign lnk.peso     = so[PE];
    assign lnk.cwdo     = dout[CW];
    assign lnk.ccwdo    = dout[CCW];
    assign lnk.pedo     = dout[PE];
    assign lnk.polarity = polarity_q;

    always_comb begin
        polarity_d = ~polarity_q;
        in_v_d     = in_v_q;
        in_f_d     = in_f_q;
        out_v_d    = out_v_q;
        out_f_d    = out_f_q;
        rr_pe_d    = rr_pe_q;
        rr_cw_d    = rr_cw_q;
        rr_ccw_d   = rr_ccw_q;

        cw_hop0     = (in_f_q[CW][v][8:15] == 8'd0);
        ccw_hop0    = (in_f_q[CCW][v][8:15] == 8'd0);
        req_cw_pe   = in_v_q[CW][v] & cw_hop0;
        req_cw_cw   = in_v_q[CW][v] & ~cw_hop0;
        req_ccw_pe  = in_v_q[CCW][v] & ccw_hop0;
        req_ccw_ccw = in_v_q[CCW][v] & ~ccw_hop0;
        req_pe_cw   = in_v_q[PE][v] & ~in_f_q[PE][v][1];
        req_pe_ccw  = in_v_q[PE][v] & in_f_q[PE][v][1];

        // A full target blocks the grant and freezes its pointer.
        g_pe  = out_v_q[PE][v]  ? 2'b00 : rr_grant(req_cw_pe, req_ccw_pe, rr_pe_q);
        g_cw  = out_v_q[CW][v]  ? 2'b00 : rr_grant(req_cw_cw, req_pe_cw, rr_cw_q);
        g_ccw = out_v_q[CCW][v] ? 2'b00 : rr_grant(req_ccw_ccw, req_pe_ccw, rr_ccw_q);

        if (!out_v_q[PE][v] && req_cw_pe && req_ccw_pe)    rr_pe_d  = ~rr_pe_q;
        if (!out_v_q[CW][v] && req_cw_cw && req_pe_cw)     rr_cw_d  = ~rr_cw_q;
        if (!out_v_q[CCW][v] && req_ccw_ccw && req_pe_ccw) rr_ccw_d = ~rr_ccw_q;

        if (g_pe[1]) begin
            out_v_d[PE][v] = 1'b1;
            out_f_d[PE][v] = in_f_q[CW][v];
            in_v_d[CW][v]  = 1'b0;
        end
        if (g_pe[0]) begin
            out_v_d[PE][v] = 1'b1;
            out_f_d[PE][v] = in_f_q[CCW][v];
            in_v_d[CCW][v] = 1'b0;
        end
        if (g_cw[1]) begin
            out_v_d[CW][v] = 1'b1;
            out_f_d[CW][v] = hop_shift(in_f_q[CW][v]);
            in_v_d[CW][v]  = 1'b0;
        end
        if (g_cw[0]) begin
            out_v_d[CW][v] = 1'b1;
            out_f_d[CW][v] = in_f_q[PE][v];
            in_v_d[PE][v]  = 1'b0;
        end
        if (g_ccw[1]) begin
            out_v_d[CCW][v] = 1'b1;
            out_f_d[CCW][v] = hop_shift(in_f_q[CCW][v]);
            in_v_d[CCW][v]  = 1'b0;
        end
        if (g_ccw[0]) begin
            out_v_d[CCW][v] = 1'b1;
            out_f_d[CCW][v] = in_f_q[PE][v];
            in_v_d[PE][v]   = 1'b0;
        end

        // Link writes land last: the flit's own VC bit picks the buffer, even if it is not p.
        for (int x = 0; x < 3; x++) begin
            if (so[x]) out_v_d[x][p] = 1'b0;
            if (si[x] && ri[x]) begin
                in_v_d[x][di[x][0]] = 1'b1;
                in_f_d[x][di[x][0]] = di[x];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity_q <= 1'b0;
            rr_pe_q    <= 1'b0;
            rr_cw_q    <= 1'b0;
            rr_ccw_q   <= 1'b0;
            for (int x = 0; x < 3; x++) begin
                in_v_q[x]  <= 2'b00;
                out_v_q[x] <= 2'b00;
                for (int c = 0; c < 2; c++) begin
                    in_f_q[x][c]  <= '0;
                    out_f_q[x][c] <= '0;
                end
            end
        end else begin
            polarity_q <= polarity_d;
            rr_pe_q    <= rr_pe_d;
            rr_cw_q    <= rr_cw_d;
            rr_ccw_q   <= rr_ccw_d;
            in_v_q     <= in_v_d;
            in_f_q     <= in_f_d;
            out_v_q    <= out_v_d;
            out_f_q    <= out_f_d;
        end
    end
endmodule

// File: tb/tb_cardinal_router.sv
// Directed bench for cardinal_router: hop delivery, forwarding, round-robin contention,
// backpressure and mid-flight reset, each against hand-computed flits.
module tb_cardinal_router;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    cardinal_router_if #(.DATA_WIDTH(64)) lnk ();
    cardinal_router #(.DATA_WIDTH(64)) dut (.clk(clk), .reset(reset), .lnk(lnk));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // {vc, dir, reserved, hop, payload} -- concatenation order puts vc on flit bit 0.
    function automatic logic [63:0] mk(input logic vc, input logic dir, input logic [7:0] hop,
                                       input logic [47:0] pl);
        return {vc, dir, 6'b000000, hop, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic align(input logic pv);
        if (lnk.polarity !== pv) tick();
    endtask

    task automatic idle();
        lnk.cwsi = 1'b0; lnk.ccwsi = 1'b0; lnk.pesi = 1'b0;
        lnk.cwdi = '0;   lnk.ccwdi = '0;   lnk.pedi = '0;
        lnk.cwro = 1'b1; lnk.ccwro = 1'b1; lnk.pero = 1'b1;
    endtask

    // One cycle on the CW-out path: drive cw/pe inputs, then check readies and CW output.
    task automatic cw_cycle(input string tag, input logic cv, input logic [63:0] cd,
                            input logic pv, input logic [63:0] pd, input logic e_cwri,
                            input logic e_peri, input logic e_so, input logic [63:0] e_do);
        lnk.cwsi = cv; lnk.cwdi = cd;
        lnk.pesi = pv; lnk.pedi = pd;
        #1;
        check({tag, "_cwri"}, lnk.cwri, e_cwri);
        check({tag, "_peri"}, lnk.peri, e_peri);
        check({tag, "_cwso"}, lnk.cwso, e_so);
        if (e_so) check({tag, "_cwdo"}, lnk.cwdo, e_do);
        tick();
    endtask

    logic [63:0] fa [3];
    logic [63:0] fb [2];
    logic [63:0] fl [3];
    int          stale;

    initial begin
        reset = 1'b0;
        idle();
        #2;
        check("rst_pol",   lnk.polarity, 0);
        check("rst_cwri",  lnk.cwri, 1);
        check("rst_ccwri", lnk.ccwri, 1);
        check("rst_peri",  lnk.peri, 1);
        check("rst_cwso",  lnk.cwso, 0);
        check("rst_ccwso", lnk.ccwso, 0);
        check("rst_peso",  lnk.peso, 0);
        check("rst_cwdo",  lnk.cwdo, 0);
        check("rst_ccwdo", lnk.ccwdo, 0);
        check("rst_pedo",  lnk.pedo, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("pol_seq", lnk.polarity, (i % 2 == 0) ? 1 : 0);
        end

        // single hop into the PE port
        align(1'b0);
        lnk.cwsi = 1'b1; lnk.cwdi = 64'h0000_0000_0000_00AA;
        #1 check("hop_cwri0", lnk.cwri, 1);
        tick();
        lnk.cwsi = 1'b0;
        #1 check("hop_peso1", lnk.peso, 0);
        check("hop_cwri1", lnk.cwri, 1);
        tick();
        #1 check("hop_peso2", lnk.peso, 1);
        check("hop_pedo2", lnk.pedo, 64'h0000_0000_0000_00AA);
        check("hop_cwri2", lnk.cwri, 1);
        tick();
        #1 check("hop_peso3", lnk.peso, 0);

        // CCW forward with hop decrement
        align(1'b1);
        lnk.ccwsi = 1'b1; lnk.ccwdi = mk(1, 1, 8'h03, 48'h1234_5678_9ABC);
        #1 check("fwd_ccwri0", lnk.ccwri, 1);
        tick();
        lnk.ccwsi = 1'b0;
        #1 check("fwd_ccwso1", lnk.ccwso, 0);
        tick();
        #1 check("fwd_ccwso2", lnk.ccwso, 1);
        check("fwd_ccwdo2", lnk.ccwdo, mk(1, 1, 8'h01, 48'h1234_5678_9ABC));
        tick();
        #1 check("fwd_ccwso3", lnk.ccwso, 0);

        // cw_in (hop 2) against pe_in (dir 0) for CW out; loser stays, winner is refilled
        for (int i = 0; i < 2; i++) fb[i] = mk(0, 0, 8'h00, 48'h0000_0000_00B0 + 48'(i));
        for (int i = 0; i < 2; i++) fa[i] = mk(0, 0, 8'h02, 48'h0000_0000_00A0 + 48'(i));
        align(1'b0);
        cw_cycle("arb_c0", 1, fa[0], 1, fb[0], 1, 1, 0, 0);
        cw_cycle("arb_c1", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("arb_c2", 1, fa[1], 0, 0, 1, 0, 1, mk(0, 0, 8'h01, 48'h00A0));
        cw_cycle("arb_c3", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("arb_c4", 0, 0, 1, fb[1], 0, 1, 1, fb[0]);
        cw_cycle("arb_c5", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("arb_c6", 0, 0, 0, 0, 1, 0, 1, mk(0, 0, 8'h01, 48'h00A1));
        cw_cycle("arb_c7", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("arb_c8", 0, 0, 0, 0, 1, 1, 1, fb[1]);
        idle();

        // CW backpressure on VC0: two flits fill the chain, the third waits
        for (int i = 0; i < 3; i++) fl[i] = mk(0, 0, 8'h01, 48'h0000_0000_00F0 + 48'(i));
        align(1'b0);
        lnk.cwro = 1'b0;
        cw_cycle("bp_c0", 1, fl[0], 0, 0, 1, 1, 0, 0);
        cw_cycle("bp_c1", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("bp_c2", 1, fl[1], 0, 0, 1, 1, 0, 0);
        cw_cycle("bp_c3", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("bp_c4", 1, fl[2], 0, 0, 0, 1, 0, 0);
        cw_cycle("bp_c5", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("bp_c6", 1, fl[2], 0, 0, 0, 1, 0, 0);
        cw_cycle("bp_c7", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("bp_c8", 1, fl[2], 0, 0, 0, 1, 0, 0);
        cw_cycle("bp_c9", 0, 0, 0, 0, 1, 1, 0, 0);
        lnk.cwro = 1'b1;
        cw_cycle("bp_c10", 1, fl[2], 0, 0, 0, 1, 1, mk(0, 0, 8'h00, 48'h00F0));
        cw_cycle("bp_c11", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("bp_c12", 1, fl[2], 0, 0, 1, 1, 1, mk(0, 0, 8'h00, 48'h00F1));
        cw_cycle("bp_c13", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("bp_c14", 0, 0, 0, 0, 1, 1, 1, mk(0, 0, 8'h00, 48'h00F2));
        cw_cycle("bp_c15", 0, 0, 0, 0, 1, 1, 0, 0);
        cw_cycle("bp_c16", 0, 0, 0, 0, 1, 1, 0, 0);
        idle();

        // reset with three flits parked behind stalled outputs
        align(1'b0);
        lnk.cwro = 1'b0; lnk.ccwro = 1'b0; lnk.pero = 1'b0;
        lnk.cwsi  = 1'b1; lnk.cwdi  = mk(0, 0, 8'h01, 48'h00C1);
        lnk.ccwsi = 1'b1; lnk.ccwdi = mk(0, 1, 8'h01, 48'h00C2);
        lnk.pesi  = 1'b1; lnk.pedi  = mk(0, 1, 8'h00, 48'h00C3);
        tick();
        lnk.cwsi = 1'b0; lnk.ccwsi = 1'b0; lnk.pesi = 1'b0;
        tick();
        #1;
        reset = 1'b0;
        lnk.cwro = 1'b1; lnk.ccwro = 1'b1; lnk.pero = 1'b1;
        #1;
        check("mid_pol",   lnk.polarity, 0);
        check("mid_cwso",  lnk.cwso, 0);
        check("mid_ccwso", lnk.ccwso, 0);
        check("mid_peso",  lnk.peso, 0);
        check("mid_cwri",  lnk.cwri, 1);
        check("mid_ccwri", lnk.ccwri, 1);
        check("mid_peri",  lnk.peri, 1);
        check("mid_ccwdo", lnk.ccwdo, 0);
        @(negedge clk);
        reset = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            check("mid_pol_seq", lnk.polarity, (i % 2 == 0) ? 1 : 0);
            stale += int'(lnk.cwso) + int'(lnk.ccwso) + int'(lnk.peso);
        end
        check("mid_stale", stale, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
